vram_write_arbiter: RTL and testbench
=====================================

// Module: vram_write_arbiter
// PURPOSE
//  Shares the single write port of the 1024x3 video memory between CPU WVM writes and a hardware fill engine.
//  The fill engine clears or paints a contiguous address range with one colour; the CPU always has priority.
//  Sits between the MiniAlu control decode and the RAM_SINGLE_READ_PORT video memory write inputs.
// PARAMETERS
//  DATA_WIDTH  3   colour bits per cell
//  ADDR_WIDTH  10  video memory address bits; address space wraps modulo 2**ADDR_WIDTH
// PORTS
//  Clock         in   1           system clock, all logic on rising edge
//  Reset         in   1           asynchronous, active-low reset
//  iCpuReq       in   1           CPU write request this cycle (WVM decode)
//  iCpuAddr      in   ADDR_WIDTH  CPU write address
//  iCpuData      in   DATA_WIDTH  CPU write colour
//  iFillStart    in   1           1-cycle pulse: begin fill, sampled only in IDLE
//  iFillAbort    in   1           stop an active fill
//  iFillBase     in   ADDR_WIDTH  first fill address
//  iFillLen      in   ADDR_WIDTH+1  number of cells to write (0..2**ADDR_WIDTH)
//  iFillColor    in   DATA_WIDTH  fill colour
//  iVBlank       in   1           vertical blank window from VGA controller (used only with macro)
//  oWriteEnable  out  1           registered write strobe to video memory
//  oWriteAddress out  ADDR_WIDTH  registered write address
//  oDataIn       out  DATA_WIDTH  registered write data
//  oFillBusy     out  1           high in FILL state
//  oFillDone     out  1           1-cycle pulse on fill completion
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, internal base/remaining/colour registers 0.
//  - Write path latency 1 cycle: a request granted in cycle N is driven on oWrite* in cycle N+1.
//  - CPU priority absolute: iCpuReq=1 always produces a CPU write next cycle; a CPU request never stalls.
//  - FSM IDLE -> FILL on iFillStart with iFillLen!=0; base, len and colour are latched at that edge.
//  - IDLE -> DONE on iFillStart with iFillLen==0; no memory write occurs.
//  - FILL: in each cycle with iCpuReq=0, issue write (base+offset, colour), offset++, remaining--.
//  - FILL: in a cycle with iCpuReq=1, the fill stalls; offset and remaining are held.
//  - FILL -> DONE when the write with remaining==1 is issued.
//  - FILL -> IDLE on iFillAbort: no done pulse; a write issued in the same cycle is suppressed.
//  - DONE: oFillDone=1 for exactly one cycle, then IDLE. iFillStart in DONE/FILL is ignored.
//  - Address = (base+offset) mod 2**ADDR_WIDTH; a range crossing 1023 wraps to 0.
//  - iFillLen=1024 writes every cell exactly once.
//  - oWriteEnable=0 in any cycle with no CPU request and no fill write issued; address and data then hold.
//  - Asserting Reset mid-fill aborts immediately with no done pulse.
// CONFIGURATION
//  - FILL_VBLANK_ONLY_EN defined: fill writes are issued only while iVBlank=1; otherwise the fill stalls
//    as on a CPU request, so no tearing is visible during the active display.
//  - FILL_VBLANK_ONLY_EN undefined: iVBlank is ignored and the fill runs whenever the CPU is idle.
// STRUCTURE
//  - Package vram_arb_pkg holds:
//      state encoding IDLE=2'd0, FILL=2'd1, DONE=2'd2;
//      localparams for the default widths;
//      VRAM_CELLS=1024.
//  - Sub-module vram_fill_counter: loadable offset/remaining counter with hold (stall) input;
//    it outputs the current address and a last-write flag.
//  - Top-level logic: FSM, priority mux, output registers.
// TESTING
//  - CPU only: iCpuReq=1, addr=10'h05A, data=3'b101 -> next cycle oWriteEnable=1, addr 05A, data 101.
//  - Fill base=0, len=4, colour=3'b010 with no CPU traffic:
//      writes to 0,1,2,3 on 4 consecutive cycles; oFillDone pulses the cycle after the write to 3.
//  - Fill base=10'h3FE, len=4 -> addresses 3FE, 3FF, 000, 001; no write outside the range.
//  - Fill len=8 with iCpuReq=1 in the 3rd fill cycle:
//      the CPU write appears in order; the fill resumes with the same address;
//      8 fill writes total, done is delayed by 1 cycle.
//  - iFillAbort after 2 fill writes -> no further fill writes; oFillBusy=0 next cycle; oFillDone never pulses.
//  - len=0 -> oFillDone pulses 2 cycles after start with zero writes.
//  - Reset low mid-fill -> outputs 0 at once and state IDLE.
//  - With FILL_VBLANK_ONLY_EN: iVBlank=0 -> no fill writes; when iVBlank rises, writes resume in order.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Purpose: shared state encoding and default geometry for the video-memory write arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vram_arb_pkg;

    localparam int DATA_WIDTH_DEF = 3;
    localparam int ADDR_WIDTH_DEF = 10;
    localparam int VRAM_CELLS     = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/vram_write_arbiter_if.sv
// Purpose: groups the CPU write request, fill-engine control and video-memory write bus.
// Latency: n/a (wiring only).
// Backpressure: none; the CPU never stalls and the fill engine absorbs all stalls internally.
interface vram_write_arbiter_if
    import vram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

    logic                  iCpuReq;
    logic [ADDR_WIDTH-1:0] iCpuAddr;
    logic [DATA_WIDTH-1:0] iCpuData;
    logic                  iFillStart;
    logic                  iFillAbort;
    logic [ADDR_WIDTH-1:0] iFillBase;
    logic [ADDR_WIDTH:0]   iFillLen;
    logic [DATA_WIDTH-1:0] iFillColor;
    logic                  iVBlank;
    logic                  oWriteEnable;
    logic [ADDR_WIDTH-1:0] oWriteAddress;
    logic [DATA_WIDTH-1:0] oDataIn;
    logic                  oFillBusy;
    logic                  oFillDone;

    modport slave (
        input  iCpuReq, iCpuAddr, iCpuData,
        input  iFillStart, iFillAbort, iFillBase, iFillLen, iFillColor, iVBlank,
        output oWriteEnable, oWriteAddress, oDataIn, oFillBusy, oFillDone
    );

    modport master (
        output iCpuReq, iCpuAddr, iCpuData,
        output iFillStart, iFillAbort, iFillBase, iFillLen, iFillColor, iVBlank,
        input  oWriteEnable, oWriteAddress, oDataIn, oFillBusy, oFillDone
    );

endinterface

// File: rtl/vram_fill_counter.sv
// Purpose: fill-range walker; loads base/length, advances one cell per step, flags the last cell.
// Latency: addr_o/last_o reflect registered state (0 cycles from state, 1 cycle from load/step).
// Backpressure: step_i low holds offset and remaining count.
module vram_fill_counter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    localparam logic [ADDR_WIDTH-1:0] OFF_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] offset_q, offset_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;

    always_comb begin
        base_d      = base_q;
        offset_d    = offset_q;
        remaining_d = remaining_q;
        if (load_i) begin
            base_d      = base_i;
            offset_d    = '0;
            remaining_d = len_i;
        end else if (step_i) begin
            offset_d    = offset_q + OFF_ONE;
            remaining_d = remaining_q - REM_ONE;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            base_q      <= '0;
            offset_q    <= '0;
            remaining_q <= '0;
        end else begin
            base_q      <= base_d;
            offset_q    <= offset_d;
            remaining_q <= remaining_d;
        end
    end

    // Address arithmetic is naturally modulo 2**ADDR_WIDTH, so ranges past the top wrap to 0.
    assign addr_o = base_q + offset_q;
    assign last_o = (remaining_q == REM_ONE);

endmodule

// File: rtl/vram_write_arbiter.sv
// Purpose: shares the video-memory write port between CPU writes (absolute priority) and a fill engine.
// Latency: 1 cycle from grant to oWrite*; FILL_VBLANK_ONLY_EN restricts fill writes to vertical blank.
// Backpressure: CPU never stalls; the fill holds its position on CPU traffic (or outside vblank).
module vram_write_arbiter
    import vram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                 Clock,
    input  logic                 Reset,
    vram_write_arbiter_if.slave  bus
);

    arb_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] color_q, color_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;

    logic                  fill_ok;
    logic                  fill_load;
    logic                  fill_issue;
    logic                  fill_last;
    logic [ADDR_WIDTH-1:0] fill_addr;

`ifdef FILL_VBLANK_ONLY_EN
    assign fill_ok = bus.iVBlank;
`else
    logic unused_vblank;
    assign unused_vblank = bus.iVBlank;
    assign fill_ok       = 1'b1;
`endif

    vram_fill_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_counter (
        .Clock  (Clock),
        .Reset  (Reset),
        .load_i (fill_load),
        .step_i (fill_issue),
        .base_i (bus.iFillBase),
        .len_i  (bus.iFillLen),
        .addr_o (fill_addr),
        .last_o (fill_last)
    );

    always_comb begin
        state_d    = state_q;
        color_d    = color_q;
        fill_load  = 1'b0;
        fill_issue = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.iFillStart) begin
                    if (bus.iFillLen != '0) begin
                        state_d   = FILL;
                        fill_load = 1'b1;
                        color_d   = bus.iFillColor;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FILL: begin
                // Abort wins over a write that would otherwise issue this cycle.
                if (bus.iFillAbort) begin
                    state_d = IDLE;
                end else if (!bus.iCpuReq && fill_ok) begin
                    fill_issue = 1'b1;
                    if (fill_last) state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        we_d   = bus.iCpuReq | fill_issue;
        addr_d = addr_q;
        data_d = data_q;
        if (bus.iCpuReq) begin
            addr_d = bus.iCpuAddr;
            data_d = bus.iCpuData;
        end else if (fill_issue) begin
            addr_d = fill_addr;
            data_d = color_q;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            color_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            color_q <= color_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign bus.oWriteEnable  = we_q;
    assign bus.oWriteAddress = addr_q;
    assign bus.oDataIn       = data_q;
    assign bus.oFillBusy     = (state_q == FILL);
    assign bus.oFillDone     = done_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: every expected memory write is queued in issue order
// and popped as oWriteEnable appears; done/busy timing is checked at fixed cycle offsets.
module tb_vram_write_arbiter;
    import vram_arb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 3;

`ifdef FILL_VBLANK_ONLY_EN
    localparam logic VB_DEF = 1'b1;
`else
    localparam logic VB_DEF = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    vram_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    vram_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    wr_t exp_q[$];
    int  total    = 0;
    int  bad      = 0;
    int  done_cnt = 0;
    int  wr_cnt   = 0;
    int  w0;
    int  d0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // One clock: sample 1 time unit after the rising edge and drain the scoreboard.
    task automatic tick();
        wr_t e;
        @(posedge Clock);
        #1;
        if (bus.oFillDone) done_cnt++;
        if (bus.oWriteEnable) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {31'd0, bus.oWriteEnable}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {22'd0, bus.oWriteAddress}, {22'd0, e.addr});
                chk("wr_data", {29'd0, bus.oDataIn}, {29'd0, e.data});
            end
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic start_fill(input logic [AW-1:0] base, input logic [AW:0] len, input logic [DW-1:0] col);
        bus.iFillBase  = base;
        bus.iFillLen   = len;
        bus.iFillColor = col;
        bus.iFillStart = 1'b1;
        tick();
        bus.iFillStart = 1'b0;
    endtask

    initial begin
        bus.iCpuReq    = 1'b0;
        bus.iCpuAddr   = '0;
        bus.iCpuData   = '0;
        bus.iFillStart = 1'b0;
        bus.iFillAbort = 1'b0;
        bus.iFillBase  = '0;
        bus.iFillLen   = '0;
        bus.iFillColor = '0;
        bus.iVBlank    = VB_DEF;

        // Reset state
        #12;
        chk("rst_we",   {31'd0, bus.oWriteEnable}, 32'd0);
        chk("rst_addr", {22'd0, bus.oWriteAddress}, 32'd0);
        chk("rst_data", {29'd0, bus.oDataIn}, 32'd0);
        chk("rst_busy", {31'd0, bus.oFillBusy}, 32'd0);
        chk("rst_done", {31'd0, bus.oFillDone}, 32'd0);
        Reset = 1'b1;

        // CPU write, then an idle cycle where address/data must hold
        bus.iCpuReq  = 1'b1;
        bus.iCpuAddr = 10'h05A;
        bus.iCpuData = 3'b101;
        push(10'h05A, 3'b101);
        tick();
        chk("cpu_we", {31'd0, bus.oWriteEnable}, 32'd1);
        bus.iCpuReq = 1'b0;
        tick();
        chk("idle_we",   {31'd0, bus.oWriteEnable}, 32'd0);
        chk("idle_addr", {22'd0, bus.oWriteAddress}, 32'h05A);
        chk("idle_data", {29'd0, bus.oDataIn}, 32'd5);

        // Fill base 0, len 4
        w0 = wr_cnt;
        for (int i = 0; i < 4; i++) push(AW'(i), 3'b010);
        start_fill(10'h000, 11'd4, 3'b010);
        chk("fill4_busy", {31'd0, bus.oFillBusy}, 32'd1);
        ticks(4);
        chk("fill4_busy_end", {31'd0, bus.oFillBusy}, 32'd0);
        chk("fill4_done_early", {31'd0, bus.oFillDone}, 32'd0);
        tick();
        chk("fill4_done", {31'd0, bus.oFillDone}, 32'd1);
        tick();
        chk("fill4_done_pulse", {31'd0, bus.oFillDone}, 32'd0);
        chk("fill4_writes", wr_cnt - w0, 32'd4);
        chk("fill4_sb_empty", exp_q.size(), 32'd0);

        // Fill across the top of the address space
        w0 = wr_cnt;
        push(10'h3FE, 3'b011);
        push(10'h3FF, 3'b011);
        push(10'h000, 3'b011);
        push(10'h001, 3'b011);
        start_fill(10'h3FE, 11'd4, 3'b011);
        ticks(5);
        chk("wrap_done", {31'd0, bus.oFillDone}, 32'd1);
        tick();
        chk("wrap_writes", wr_cnt - w0, 32'd4);
        chk("wrap_sb_empty", exp_q.size(), 32'd0);

        // CPU write in the 3rd fill cycle stalls the fill by one cycle
        w0 = wr_cnt;
        push(10'h100, 3'b110);
        push(10'h101, 3'b110);
        push(10'h2AA, 3'b001);
        for (int i = 2; i < 8; i++) push(AW'(10'h100 + i), 3'b110);
        start_fill(10'h100, 11'd8, 3'b110);
        ticks(2);
        bus.iCpuReq  = 1'b1;
        bus.iCpuAddr = 10'h2AA;
        bus.iCpuData = 3'b001;
        tick();
        bus.iCpuReq = 1'b0;
        chk("stall_busy", {31'd0, bus.oFillBusy}, 32'd1);
        ticks(6);
        chk("stall_done_late", {31'd0, bus.oFillDone}, 32'd0);
        tick();
        chk("stall_done", {31'd0, bus.oFillDone}, 32'd1);
        chk("stall_writes", wr_cnt - w0, 32'd9);
        chk("stall_sb_empty", exp_q.size(), 32'd0);

        // Abort after two fill writes
        w0 = wr_cnt;
        d0 = done_cnt;
        push(10'h050, 3'b111);
        push(10'h051, 3'b111);
        start_fill(10'h050, 11'd8, 3'b111);
        ticks(2);
        chk("abort_busy_pre", {31'd0, bus.oFillBusy}, 32'd1);
        bus.iFillAbort = 1'b1;
        tick();
        bus.iFillAbort = 1'b0;
        chk("abort_busy", {31'd0, bus.oFillBusy}, 32'd0);
        ticks(5);
        chk("abort_writes", wr_cnt - w0, 32'd2);
        chk("abort_no_done", done_cnt - d0, 32'd0);

        // Zero-length fill: done two cycles after start, no writes
        w0 = wr_cnt;
        start_fill(10'h123, 11'd0, 3'b111);
        chk("len0_done_c1", {31'd0, bus.oFillDone}, 32'd0);
        tick();
        chk("len0_done_c2", {31'd0, bus.oFillDone}, 32'd1);
        tick();
        chk("len0_done_c3", {31'd0, bus.oFillDone}, 32'd0);
        chk("len0_writes", wr_cnt - w0, 32'd0);

        // Full-memory fill; a start pulse during FILL must be ignored
        w0 = wr_cnt;
        for (int i = 0; i < VRAM_CELLS; i++) push(AW'(10'h155 + i), 3'b100);
        start_fill(10'h155, 11'd1024, 3'b100);
        ticks(10);
        bus.iFillStart = 1'b1;
        bus.iFillLen   = '0;
        tick();
        bus.iFillStart = 1'b0;
        chk("full_busy", {31'd0, bus.oFillBusy}, 32'd1);
        ticks(1013);
        chk("full_done_early", {31'd0, bus.oFillDone}, 32'd0);
        tick();
        chk("full_done", {31'd0, bus.oFillDone}, 32'd1);
        chk("full_writes", wr_cnt - w0, 32'd1024);
        chk("full_sb_empty", exp_q.size(), 32'd0);

        // Reset asserted mid-fill
        w0 = wr_cnt;
        d0 = done_cnt;
        push(10'h200, 3'b001);
        push(10'h201, 3'b001);
        start_fill(10'h200, 11'd8, 3'b001);
        ticks(2);
        #2;
        Reset = 1'b0;
        #1;
        chk("mrst_we",   {31'd0, bus.oWriteEnable}, 32'd0);
        chk("mrst_addr", {22'd0, bus.oWriteAddress}, 32'd0);
        chk("mrst_data", {29'd0, bus.oDataIn}, 32'd0);
        chk("mrst_busy", {31'd0, bus.oFillBusy}, 32'd0);
        #2;
        Reset = 1'b1;
        ticks(10);
        chk("mrst_writes", wr_cnt - w0, 32'd2);
        chk("mrst_no_done", done_cnt - d0, 32'd0);
        chk("mrst_sb_empty", exp_q.size(), 32'd0);

`ifdef FILL_VBLANK_ONLY_EN
        // Fill held off outside vertical blank, resumes in order when it rises
        w0 = wr_cnt;
        for (int i = 0; i < 4; i++) push(AW'(10'h300 + i), 3'b010);
        bus.iVBlank = 1'b0;
        start_fill(10'h300, 11'd4, 3'b010);
        ticks(3);
        chk("vb_no_writes", wr_cnt - w0, 32'd0);
        bus.iVBlank = 1'b1;
        ticks(5);
        chk("vb_done", {31'd0, bus.oFillDone}, 32'd1);
        chk("vb_writes", wr_cnt - w0, 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
